serial_word_receiver: RTL and testbench



---
 rtl/serial_word_receiver.sv | 182 ++++++++++++++++++
 tb/tb_serial_word_receiver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : serial_word_receiver
// Brief    : Oversampled start/data/parity/stop receiver producing parallel
//            words with valid, framing-error and parity-error strobes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module serial_word_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] word_out,
    output logic                  word_valid,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  busy
);

    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_HALF = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_FULL = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_ONE   = c_BIT_W'(1);
    localparam logic                c_PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t                r_state;
    logic [1:0]            r_sync;
    logic [c_TICK_W-1:0]   r_tick;
    logic [c_BIT_W-1:0]    r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_bad;

    state_t                w_state_nxt;
    logic [c_TICK_W-1:0]   w_tick_nxt;
    logic [c_BIT_W-1:0]    w_bit_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_par_bad_nxt;
    logic [DATA_WIDTH-1:0] w_word_nxt;
    logic                  w_valid_nxt;
    logic                  w_ferr_nxt;
    logic                  w_perr_nxt;
    logic                  w_rx_s;

    assign w_rx_s = r_sync[1];
    assign busy   = (r_state != S_IDLE);

    // Synchroniser resets to the idle line level so reset cannot fake a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick     <= w_tick_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par_bad  <= w_par_bad_nxt;
            word_out   <= w_word_nxt;
            word_valid <= w_valid_nxt;
            frame_err  <= w_ferr_nxt;
            parity_err <= w_perr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = r_tick;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_par_bad_nxt = r_par_bad;
        w_word_nxt    = word_out;
        w_valid_nxt   = 1'b0;
        w_ferr_nxt    = 1'b0;
        w_perr_nxt    = 1'b0;

        if (sample_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt   = S_START;
                        w_tick_nxt    = '0;
                        w_bit_nxt     = '0;
                        w_par_bad_nxt = 1'b0;
                    end
                end
                S_START: begin
                    if (r_tick == c_TICK_HALF) begin
                        w_tick_nxt  = '0;
                        w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        w_tick_nxt = r_tick + c_TICK_ONE;
                    end
                end
                S_DATA: begin
                    if (r_tick == c_TICK_FULL) begin
                        w_tick_nxt  = '0;
                        // LSB-first line: shifting in at the top leaves bit 0 first-received
                        w_shift_nxt = {w_rx_s, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit == c_BIT_LAST) begin
                            w_bit_nxt   = '0;
                            w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            w_bit_nxt = r_bit + c_BIT_ONE;
                        end
                    end else begin
                        w_tick_nxt = r_tick + c_TICK_ONE;
                    end
                end
                S_PARITY: begin
                    if (r_tick == c_TICK_FULL) begin
                        w_tick_nxt    = '0;
                        w_par_bad_nxt = (w_rx_s != ((^r_shift) ^ c_PAR_ODD));
                        w_state_nxt   = S_STOP;
                    end else begin
                        w_tick_nxt = r_tick + c_TICK_ONE;
                    end
                end
                S_STOP: begin
                    if (r_tick == c_TICK_FULL) begin
                        w_tick_nxt = '0;
                        if (!w_rx_s) begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = S_WAIT_IDLE;
                        end else if (r_par_bad) begin
                            w_perr_nxt  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_word_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick + c_TICK_ONE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
`default_nettype none
// Bench: frame-level model predicts each strobe's kind, word and cycle from the
// bit stream driven; a negedge process compares both DUT instances every cycle.
module tb_serial_word_receiver;

    localparam int OS = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sample_tick = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;

    logic [7:0] wo0, wo1;
    logic wv0, fe0, pe0, bz0;
    logic wv1, fe1, pe1, bz1;

    serial_word_receiver #(.DATA_WIDTH(DW), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx_in(rx0),
        .word_out(wo0), .word_valid(wv0), .frame_err(fe0), .parity_err(pe0), .busy(bz0)
    );

    serial_word_receiver #(.DATA_WIDTH(DW), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx_in(rx1),
        .word_out(wo1), .word_valid(wv1), .frame_err(fe1), .parity_err(pe1), .busy(bz1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        logic [2:0] kind;   // {valid, frame_err, parity_err}
        logic [7:0] word;
        int         cyc;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] model_word [2];
    int         wv_cnt [2];
    int         fe_cnt [2];
    int         pe_cnt [2];
    int         wv_cyc0[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_cycle(input int d, input logic v, input logic f, input logic p,
                               input logic [7:0] w);
        logic [2:0] exp_bits;
        exp_bits = 3'b000;
        if (exp_q.size() > 0 && exp_q[0].dut == d && exp_q[0].cyc < cyc) begin
            check($sformatf("missed_pulse_d%0d", d), 32'(exp_q[0].cyc), 32'(cyc));
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].dut == d && exp_q[0].cyc == cyc) begin
            exp_bits = exp_q[0].kind;
            if (exp_q[0].kind[2]) model_word[d] = exp_q[0].word;
            void'(exp_q.pop_front());
        end
        check($sformatf("strobes_d%0d", d), {29'd0, v, f, p}, {29'd0, exp_bits});
        check($sformatf("word_out_d%0d", d), {24'd0, w}, {24'd0, model_word[d]});
        if (v) wv_cnt[d]++;
        if (f) fe_cnt[d]++;
        if (p) pe_cnt[d]++;
        if (v && d == 0) wv_cyc0.push_back(cyc);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            model_word[0] = 8'h00;
            model_word[1] = 8'h00;
        end else begin
            check_cycle(0, wv0, fe0, pe0, wo0);
            check_cycle(1, wv1, fe1, pe1, wo1);
        end
    end

    task automatic drive_line(input int d, input logic b, input int n);
        if (d == 0) rx0 = b; else rx1 = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, data and (for dut 1) parity; the caller drives the stop bit.
    task automatic send_frame(input int d, input logic [7:0] data, input logic par_bit,
                              input bit stop_good);
        ev_t e;
        int  pbits;
        pbits = (d == 1) ? 1 : 0;
        e.dut  = d;
        e.word = data;
        // 2 sync flops + 1 detect, half start bit, then full bits up to mid stop
        e.cyc  = cyc + 3 + OS / 2 + OS * (DW + pbits + 1);
        if (!stop_good)                                 e.kind = 3'b010;
        else if (pbits == 1 && par_bit != (^data))      e.kind = 3'b001;
        else                                            e.kind = 3'b100;
        exp_q.push_back(e);
        drive_line(d, 1'b0, OS);
        for (int i = 0; i < DW; i++) drive_line(d, data[i], OS);
        if (pbits == 1) drive_line(d, par_bit, OS);
    endtask

    initial begin
        int base;
        logic [7:0] partial;
        model_word[0] = 8'h00;
        model_word[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            wv_cnt[i] = 0; fe_cnt[i] = 0; pe_cnt[i] = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_word0", {24'd0, wo0}, 32'h00);
        check("rst_strobes0", {29'd0, wv0, fe0, pe0}, 32'd0);
        check("rst_busy0", {31'd0, bz0}, 32'd0);
        check("rst_busy1", {31'd0, bz1}, 32'd0);
        reset = 1'b0;
        drive_line(0, 1'b1, 10);

        // Start-bit glitch: 4 ticks low
        drive_line(0, 1'b0, 4);
        drive_line(0, 1'b1, 30);
        check("glitch_busy", {31'd0, bz0}, 32'd0);
        check("glitch_word", {24'd0, wo0}, 32'h00);
        check("glitch_pulses", 32'(wv_cnt[0] + fe_cnt[0] + pe_cnt[0]), 32'd0);

        // Single clean frame
        send_frame(0, 8'h41, 1'b0, 1'b1);
        drive_line(0, 1'b1, OS);
        drive_line(0, 1'b1, 4);
        check("f41_word", {24'd0, wo0}, 32'h41);
        check("f41_valid_cnt", 32'(wv_cnt[0]), 32'd1);
        check("f41_busy", {31'd0, bz0}, 32'd0);

        // Back-to-back 0xAA, 0xAA
        send_frame(0, 8'hAA, 1'b0, 1'b1);
        drive_line(0, 1'b1, OS);
        send_frame(0, 8'hAA, 1'b0, 1'b1);
        drive_line(0, 1'b1, OS);
        drive_line(0, 1'b1, 4);
        check("aa_word", {24'd0, wo0}, 32'hAA);
        check("aa_valid_cnt", 32'(wv_cnt[0]), 32'd3);
        if (wv_cyc0.size() >= 3)
            check("aa_spacing", 32'(wv_cyc0[2] - wv_cyc0[1]), 32'd160);
        else
            check("aa_spacing_count", 32'(wv_cyc0.size()), 32'd3);

        // Stop bit held low for 40 ticks
        send_frame(0, 8'h5C, 1'b0, 1'b0);
        drive_line(0, 1'b0, 30);
        check("brk_busy_high", {31'd0, bz0}, 32'd1);
        check("brk_ferr_cnt", 32'(fe_cnt[0]), 32'd1);
        drive_line(0, 1'b0, 10);
        drive_line(0, 1'b1, 20);
        check("brk_busy_low", {31'd0, bz0}, 32'd0);
        check("brk_word_kept", {24'd0, wo0}, 32'hAA);
        send_frame(0, 8'h12, 1'b0, 1'b1);
        drive_line(0, 1'b1, OS);
        drive_line(0, 1'b1, 4);
        check("f12_word", {24'd0, wo0}, 32'h12);

        // Even parity instance
        send_frame(1, 8'h03, 1'b1, 1'b1);
        drive_line(1, 1'b1, OS);
        drive_line(1, 1'b1, 4);
        check("par_bad_cnt", 32'(pe_cnt[1]), 32'd1);
        check("par_bad_novalid", 32'(wv_cnt[1]), 32'd0);
        check("par_bad_word", {24'd0, wo1}, 32'h00);
        send_frame(1, 8'h03, 1'b0, 1'b1);
        drive_line(1, 1'b1, OS);
        drive_line(1, 1'b1, 4);
        check("par_ok_word", {24'd0, wo1}, 32'h03);
        check("par_ok_cnt", 32'(wv_cnt[1]), 32'd1);

        // Reset after 4 data bits of 0xF0
        base = wv_cnt[0] + fe_cnt[0] + pe_cnt[0];
        partial = 8'hF0;
        drive_line(0, 1'b0, OS);
        for (int i = 0; i < 4; i++) drive_line(0, partial[i], OS);
        reset = 1'b1;
        #1;
        check("mid_rst_word", {24'd0, wo0}, 32'h00);
        check("mid_rst_busy", {31'd0, bz0}, 32'd0);
        check("mid_rst_strobes", {29'd0, wv0, fe0, pe0}, 32'd0);
        rx0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        drive_line(0, 1'b1, 200);
        check("mid_rst_nopulse", 32'(wv_cnt[0] + fe_cnt[0] + pe_cnt[0]), 32'(base));
        send_frame(0, 8'h99, 1'b0, 1'b1);
        drive_line(0, 1'b1, OS);
        drive_line(0, 1'b1, 4);
        check("f99_word", {24'd0, wo0}, 32'h99);

        check("events_left", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
